traffic_lights_multi: RTL and testbench

TRAFFIC_LIGHTS_MULTI -- requirements
Module: traffic_lights_multi

---
 rtl/traffic_lights_pkg.sv | 39 +++
 rtl/tl_ms_timer.sv | 53 +++++
 rtl/traffic_lights_multi.sv | 253 +++++++++++++++++++++++++
 tb/tb_traffic_lights_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_lights_pkg.sv
// -----------------------------------------------------------------------------
// traffic_lights_pkg
// Shared definitions for the multi-approach traffic light controller:
//   - state_t   : controller state encoding
//   - CMD_*     : command codes carried on cmd_type_i
//   - time_t    : 16-bit millisecond time value
//   - clamp_time: maps a programmed time of 0 ms to 1 ms
// -----------------------------------------------------------------------------
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_BLINK       = 3'd1,
        ST_ALL_RED     = 3'd2,
        ST_RED_YELLOW  = 3'd3,
        ST_GREEN       = 3'd4,
        ST_GREEN_BLINK = 3'd5,
        ST_YELLOW      = 3'd6
    } state_t;

    localparam logic [2:0] CMD_ON          = 3'd0;
    localparam logic [2:0] CMD_OFF         = 3'd1;
    localparam logic [2:0] CMD_BLINK       = 3'd2;
    localparam logic [2:0] CMD_SET_GREEN   = 3'd3;
    localparam logic [2:0] CMD_SET_ALL_RED = 3'd4;
    localparam logic [2:0] CMD_SET_YELLOW  = 3'd5;

    typedef logic [15:0] time_t;

    // A zero duration would never expire cleanly, so it is stored as 1 ms.
    function automatic time_t clamp_time(input time_t t);
        if (t == 16'd0) begin
            return 16'd1;
        end else begin
            return t;
        end
    endfunction

endpackage

// File: rtl/tl_ms_timer.sv
// -----------------------------------------------------------------------------
// tl_ms_timer
// Millisecond prescaler plus millisecond down-counter.
//   clk_i, arst_n_i : clock, asynchronous active-low reset
//   load_i, ms_i    : restart the period with a duration of ms_i milliseconds
//   run_i           : count while high (start/enable)
//   tick_o          : last clock cycle of each millisecond
//   expire_o        : last clock cycle of the loaded period
// After a load the period lasts exactly ms_i * CLK_PER_MS cycles, with
// expire_o high in its final cycle.
// -----------------------------------------------------------------------------
module tl_ms_timer
    import traffic_lights_pkg::*;
#(
    parameter int CLK_PER_MS = 1000
) (
    input  logic  clk_i,
    input  logic  arst_n_i,
    input  logic  load_i,
    input  time_t ms_i,
    input  logic  run_i,
    output logic  tick_o,
    output logic  expire_o
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] pre_r;
    time_t         ms_r;

    // Prescaler and millisecond counter; a load restarts both.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pre_r <= '0;
            ms_r  <= 16'd0;
        end else if (load_i) begin
            pre_r <= PRE_MAX;
            ms_r  <= ms_i - 16'd1;
        end else if (run_i) begin
            if (pre_r == '0) begin
                pre_r <= PRE_MAX;
                ms_r  <= ms_r - 16'd1;
            end else begin
                pre_r <= pre_r - 1'b1;
            end
        end
    end

    assign tick_o   = run_i && (pre_r == '0);
    assign expire_o = tick_o && (ms_r == 16'd0);

endmodule

// File: rtl/traffic_lights_multi.sv
// -----------------------------------------------------------------------------
// traffic_lights_multi
// Traffic light controller serving DIR_NUM approaches in rotation.
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_type_i   : one-cycle command (ON/OFF/BLINK/SET_*)
//   cmd_dir_i, cmd_data_i    : SET_GREEN target approach, time in ms
//   red_o/yellow_o/green_o   : registered lamps per approach
//   active_dir_o             : approach currently served (0 in OFF/BLINK)
// Optional macro TRAFFIC_LIGHTS_PED_EN adds ped_req_i (pedestrian request per
// approach) and walk_o (walk lamp per approach).
// -----------------------------------------------------------------------------
module traffic_lights_multi
    import traffic_lights_pkg::*;
#(
    parameter int DIR_NUM        = 2,
    parameter int CLK_PER_MS     = 1000,
    parameter int GREEN_DEF_MS   = 10,
    parameter int YELLOW_DEF_MS  = 3,
    parameter int ALL_RED_DEF_MS = 2,
    parameter int RY_MS          = 2,
    parameter int G_BLINK_MS     = 4,
    parameter int BLINK_HALF_MS  = 1
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cmd_valid_i,
    input  logic [2:0]                 cmd_type_i,
    input  logic [$clog2(DIR_NUM)-1:0] cmd_dir_i,
    input  logic [15:0]                cmd_data_i,
    output logic [DIR_NUM-1:0]         red_o,
    output logic [DIR_NUM-1:0]         yellow_o,
    output logic [DIR_NUM-1:0]         green_o,
    output logic [$clog2(DIR_NUM)-1:0] active_dir_o
`ifdef TRAFFIC_LIGHTS_PED_EN
    ,
    input  logic [DIR_NUM-1:0]         ped_req_i,
    output logic [DIR_NUM-1:0]         walk_o
`endif
);

    localparam int DW = $clog2(DIR_NUM);

    state_t         state_r, state_n;
    logic [DW-1:0]  d_r, d_n, d_inc_s;
    time_t          green_r [DIR_NUM];
    time_t          yellow_r, all_red_r;
    logic           load_s, tick_s, expire_s;
    time_t          load_ms_s;
    logic           phase_r, phase_n;
    logic [15:0]    bcnt_r, bcnt_n;
    logic [DIR_NUM-1:0] red_n, yellow_n, green_n;

    tl_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .load_i   (load_s),
        .ms_i     (load_ms_s),
        .run_i    (state_r != ST_OFF),
        .tick_o   (tick_s),
        .expire_o (expire_s)
    );

    assign d_inc_s = (d_r == DW'(DIR_NUM - 1)) ? '0 : d_r + 1'b1;

    // Next state: effective commands override a coincident timer expiry.
    always_comb begin
        state_n   = state_r;
        d_n       = d_r;
        load_s    = 1'b0;
        load_ms_s = 16'd1;
        if (cmd_valid_i && cmd_type_i == CMD_OFF) begin
            state_n = ST_OFF;
            d_n     = '0;
        end else if (cmd_valid_i && cmd_type_i == CMD_BLINK &&
                     state_r != ST_OFF && state_r != ST_BLINK) begin
            // Timer only feeds the blink ticks here; its expiry is unused.
            state_n = ST_BLINK;
            d_n     = '0;
            load_s  = 1'b1;
        end else if (cmd_valid_i && cmd_type_i == CMD_ON &&
                     (state_r == ST_OFF || state_r == ST_BLINK)) begin
            state_n   = ST_ALL_RED;
            d_n       = '0;
            load_s    = 1'b1;
            load_ms_s = all_red_r;
        end else if (expire_s) begin
            load_s = 1'b1;
            case (state_r)
                ST_ALL_RED: begin
                    state_n   = ST_RED_YELLOW;
                    load_ms_s = 16'(RY_MS);
                end
                ST_RED_YELLOW: begin
                    state_n   = ST_GREEN;
                    load_ms_s = green_r[d_r];
                end
                ST_GREEN: begin
                    state_n   = ST_GREEN_BLINK;
                    load_ms_s = 16'(G_BLINK_MS);
                end
                ST_GREEN_BLINK: begin
                    state_n   = ST_YELLOW;
                    load_ms_s = yellow_r;
                end
                ST_YELLOW: begin
                    state_n   = ST_ALL_RED;
                    d_n       = d_inc_s;
                    load_ms_s = all_red_r;
                end
                default: begin
                    load_s = 1'b0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Blink phase: restarts "on" at every state entry, toggles each half period.
    always_comb begin
        phase_n = phase_r;
        bcnt_n  = bcnt_r;
        if (state_n != state_r) begin
            phase_n = 1'b1;
            bcnt_n  = 16'd0;
        end else if (tick_s) begin
            if (bcnt_r == 16'(BLINK_HALF_MS - 1)) begin
                bcnt_n  = 16'd0;
                phase_n = ~phase_r;
            end else begin
                bcnt_n = bcnt_r + 16'd1;
            end
        end else begin
            bcnt_n = bcnt_r;
        end
    end

    // Lamp pattern for the upcoming cycle, so registered lamps track the state.
    always_comb begin
        red_n    = '1;
        yellow_n = '0;
        green_n  = '0;
        case (state_n)
            ST_OFF: begin
                red_n = '0;
            end
            ST_BLINK: begin
                red_n    = '0;
                yellow_n = {DIR_NUM{phase_n}};
            end
            ST_RED_YELLOW: begin
                yellow_n[d_n] = 1'b1;
            end
            ST_GREEN: begin
                red_n[d_n]   = 1'b0;
                green_n[d_n] = 1'b1;
            end
            ST_GREEN_BLINK: begin
                red_n[d_n]   = 1'b0;
                green_n[d_n] = phase_n;
            end
            ST_YELLOW: begin
                red_n[d_n]    = 1'b0;
                yellow_n[d_n] = 1'b1;
            end
            default: begin
                red_n = '1;
            end
        endcase
    end

    // State, served approach, blink phase and lamp registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r  <= ST_OFF;
            d_r      <= '0;
            phase_r  <= 1'b0;
            bcnt_r   <= 16'd0;
            red_o    <= '0;
            yellow_o <= '0;
            green_o  <= '0;
        end else begin
            state_r  <= state_n;
            d_r      <= d_n;
            phase_r  <= phase_n;
            bcnt_r   <= bcnt_n;
            red_o    <= red_n;
            yellow_o <= yellow_n;
            green_o  <= green_n;
        end
    end

    // Programmable times; writable only while blinking.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < DIR_NUM; i++) begin
                green_r[i] <= 16'(GREEN_DEF_MS);
            end
            yellow_r  <= 16'(YELLOW_DEF_MS);
            all_red_r <= 16'(ALL_RED_DEF_MS);
        end else if (cmd_valid_i && state_r == ST_BLINK) begin
            case (cmd_type_i)
                CMD_SET_GREEN: begin
                    if (int'(cmd_dir_i) < DIR_NUM) begin
                        green_r[cmd_dir_i] <= clamp_time(cmd_data_i);
                    end
                end
                CMD_SET_ALL_RED: all_red_r <= clamp_time(cmd_data_i);
                CMD_SET_YELLOW:  yellow_r  <= clamp_time(cmd_data_i);
                default: ;
            endcase
        end
    end

    assign active_dir_o = d_r;

`ifdef TRAFFIC_LIGHTS_PED_EN
    logic [DIR_NUM-1:0] ped_lat_r, ped_lat_n, walk_n;

    // Walk for approach k runs during the GREEN of the following approach;
    // its request latch clears as that GREEN ends.
    always_comb begin
        ped_lat_n = ped_lat_r | ped_req_i;
        walk_n    = '0;
        for (int k = 0; k < DIR_NUM; k++) begin
            if (state_r == ST_GREEN && state_n != ST_GREEN &&
                d_r == DW'((k + 1) % DIR_NUM)) begin
                ped_lat_n[k] = 1'b0;
            end else begin
                ped_lat_n[k] = ped_lat_n[k];
            end
            if (ped_lat_n[k] && state_n == ST_GREEN &&
                d_n == DW'((k + 1) % DIR_NUM)) begin
                walk_n[k] = 1'b1;
            end else begin
                walk_n[k] = 1'b0;
            end
        end
    end

    // Pedestrian latch and walk lamp registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ped_lat_r <= '0;
            walk_o    <= '0;
        end else begin
            ped_lat_r <= ped_lat_n;
            walk_o    <= walk_n;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_lights_multi.sv
// -----------------------------------------------------------------------------
// tb_traffic_lights_multi
// Directed bench for traffic_lights_multi with DIR_NUM=3, CLK_PER_MS=4.
// Expected lamp patterns and state durations are written out by hand.
// -----------------------------------------------------------------------------
module tb_traffic_lights_multi;
    import traffic_lights_pkg::*;

`ifdef TRAFFIC_LIGHTS_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif
    localparam logic [2:0] WALK0 = PED ? 3'b001 : 3'b000;

    logic        clk;
    logic        arst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_dir;
    logic [15:0] cmd_data;
    logic [2:0]  red, yellow, green;
    logic [1:0]  active_dir;
`ifdef TRAFFIC_LIGHTS_PED_EN
    logic [2:0]  ped_req;
    logic [2:0]  walk;
`endif

    int tests = 0;
    int fails = 0;

    traffic_lights_multi #(.DIR_NUM(3), .CLK_PER_MS(4)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_type_i   (cmd_type),
        .cmd_dir_i    (cmd_dir),
        .cmd_data_i   (cmd_data),
        .red_o        (red),
        .yellow_o     (yellow),
        .green_o      (green),
        .active_dir_o (active_dir)
`ifdef TRAFFIC_LIGHTS_PED_EN
        ,
        .ped_req_i    (ped_req),
        .walk_o       (walk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string tag, input logic [2:0] r, input logic [2:0] y,
                              input logic [2:0] g, input logic [1:0] d, input logic [2:0] w);
        logic [2:0] wo;
`ifdef TRAFFIC_LIGHTS_PED_EN
        wo = walk;
`else
        wo = 3'b000;
`endif
        tests++;
        assert ({red, yellow, green, active_dir, wo} === {r, y, g, d, w}) else begin
            fails++;
            $error("FAIL %s: got r=%b y=%b g=%b d=%0d w=%b, expected r=%b y=%b g=%b d=%0d w=%b",
                   tag, red, yellow, green, active_dir, wo, r, y, g, d, w);
        end
    endtask

    // Check the same pattern for n consecutive cycles; any armed command or
    // pedestrian request is presented during the first of those cycles only.
    task automatic hold(input string tag, input int n, input logic [2:0] r, input logic [2:0] y,
                        input logic [2:0] g, input logic [1:0] d, input logic [2:0] w);
        for (int i = 0; i < n; i++) begin
            expect_now(tag, r, y, g, d, w);
            step();
            cmd_valid = 1'b0;
`ifdef TRAFFIC_LIGHTS_PED_EN
            ped_req = 3'b000;
`endif
        end
    endtask

    task automatic arm(input logic [2:0] t, input logic [1:0] dir, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_dir   = dir;
        cmd_data  = data;
    endtask

    task automatic issue(input logic [2:0] t, input logic [1:0] dir, input logic [15:0] data);
        arm(t, dir, data);
        step();
        cmd_valid = 1'b0;
    endtask

    // GREEN_BLINK of approach d: green on/off in 4-cycle halves.
    task automatic gblink(input string tag, input logic [2:0] r, input logic [2:0] gm,
                          input logic [1:0] d);
        hold(tag, 4, r, 3'b000, gm, d, 3'b000);
        hold(tag, 4, r, 3'b000, 3'b000, d, 3'b000);
        hold(tag, 4, r, 3'b000, gm, d, 3'b000);
        hold(tag, 4, r, 3'b000, 3'b000, d, 3'b000);
    endtask

    initial begin
        arst_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 3'd0;
        cmd_dir   = 2'd0;
        cmd_data  = 16'd0;
`ifdef TRAFFIC_LIGHTS_PED_EN
        ped_req   = 3'b000;
`endif
        step();
        step();
        expect_now("reset", 3'b000, 3'b000, 3'b000, 2'd0, 3'b000);
        arst_n = 1'b1;
        hold("off_idle", 3, 3'b000, 3'b000, 3'b000, 2'd0, 3'b000);

        // Default cycle for approach 0, then into approach 1.
        issue(CMD_ON, 2'd0, 16'd0);
        hold("ar0", 8, 3'b111, 3'b000, 3'b000, 2'd0, 3'b000);
        arm(CMD_ON, 2'd0, 16'd0);                // ON outside OFF/BLINK is ignored
        hold("ry0", 8, 3'b111, 3'b001, 3'b000, 2'd0, 3'b000);
`ifdef TRAFFIC_LIGHTS_PED_EN
        ped_req = 3'b001;
`endif
        hold("g0", 40, 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
        gblink("gb0", 3'b110, 3'b001, 2'd0);
        hold("y0", 12, 3'b110, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("ar1", 8, 3'b111, 3'b000, 3'b000, 2'd1, 3'b000);
        hold("ry1", 8, 3'b111, 3'b010, 3'b000, 2'd1, 3'b000);
        hold("g1_walk", 40, 3'b101, 3'b000, 3'b010, 2'd1, WALK0);
        hold("gb1_start", 1, 3'b101, 3'b000, 3'b010, 2'd1, 3'b000);

        // BLINK, reprogramming, then a full rotation with new times.
        issue(CMD_BLINK, 2'd0, 16'd0);
        hold("blink_on", 4, 3'b000, 3'b111, 3'b000, 2'd0, 3'b000);
        hold("blink_off", 4, 3'b000, 3'b000, 3'b000, 2'd0, 3'b000);
        hold("blink_on2", 1, 3'b000, 3'b111, 3'b000, 2'd0, 3'b000);
        issue(CMD_SET_GREEN, 2'd2, 16'd5);
        issue(CMD_SET_YELLOW, 2'd0, 16'd0);
        issue(CMD_SET_GREEN, 2'd3, 16'd1);       // out-of-range approach
        issue(CMD_ON, 2'd0, 16'd0);
        hold("ar0b", 8, 3'b111, 3'b000, 3'b000, 2'd0, 3'b000);
        hold("ry0b", 8, 3'b111, 3'b001, 3'b000, 2'd0, 3'b000);
        arm(CMD_SET_GREEN, 2'd1, 16'd1);         // ignored outside BLINK
        hold("g0b", 40, 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
        gblink("gb0b", 3'b110, 3'b001, 2'd0);
        hold("y0_1ms", 4, 3'b110, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("ar1b", 8, 3'b111, 3'b000, 3'b000, 2'd1, 3'b000);
        hold("ry1b", 8, 3'b111, 3'b010, 3'b000, 2'd1, 3'b000);
        hold("g1_unchanged", 40, 3'b101, 3'b000, 3'b010, 2'd1, 3'b000);
        gblink("gb1b", 3'b101, 3'b010, 2'd1);
        hold("y1_1ms", 4, 3'b101, 3'b010, 3'b000, 2'd1, 3'b000);
        hold("ar2", 8, 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);
        hold("ry2", 8, 3'b111, 3'b100, 3'b000, 2'd2, 3'b000);
        hold("g2_5ms", 20, 3'b011, 3'b000, 3'b100, 2'd2, 3'b000);
        gblink("gb2", 3'b011, 3'b100, 2'd2);
        hold("y2_1ms", 4, 3'b011, 3'b100, 3'b000, 2'd2, 3'b000);
        hold("ar0_wrap", 8, 3'b111, 3'b000, 3'b000, 2'd0, 3'b000);
        hold("ry0c", 8, 3'b111, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("g0c", 39, 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
        arm(CMD_OFF, 2'd0, 16'd0);               // coincides with GREEN expiry
        hold("g0c_last", 1, 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
        hold("off_at_expiry", 3, 3'b000, 3'b000, 3'b000, 2'd0, 3'b000);

        // Asynchronous reset in the middle of YELLOW(1).
        issue(CMD_ON, 2'd0, 16'd0);
        hold("ar0d", 8, 3'b111, 3'b000, 3'b000, 2'd0, 3'b000);
        hold("ry0d", 8, 3'b111, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("g0d", 40, 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
        gblink("gb0d", 3'b110, 3'b001, 2'd0);
        hold("y0d", 4, 3'b110, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("ar1d", 8, 3'b111, 3'b000, 3'b000, 2'd1, 3'b000);
        hold("ry1d", 8, 3'b111, 3'b010, 3'b000, 2'd1, 3'b000);
        hold("g1d", 40, 3'b101, 3'b000, 3'b010, 2'd1, 3'b000);
        gblink("gb1d", 3'b101, 3'b010, 2'd1);
        hold("y1d", 2, 3'b101, 3'b010, 3'b000, 2'd1, 3'b000);
        #2;
        arst_n = 1'b0;
        #1;
        expect_now("rst_async", 3'b000, 3'b000, 3'b000, 2'd0, 3'b000);
        #2;
        arst_n = 1'b1;
        hold("off_after_rst", 5, 3'b000, 3'b000, 3'b000, 2'd0, 3'b000);
        issue(CMD_ON, 2'd0, 16'd0);
        hold("ar0e", 8, 3'b111, 3'b000, 3'b000, 2'd0, 3'b000);
        hold("ry0e", 8, 3'b111, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("g0e", 40, 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
        gblink("gb0e", 3'b110, 3'b001, 2'd0);
        hold("y0_default", 12, 3'b110, 3'b001, 3'b000, 2'd0, 3'b000);
        hold("ar1e", 1, 3'b111, 3'b000, 3'b000, 2'd1, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
